clause_dispatch_ctrl: RTL and testbench
=======================================

Name: clause_dispatch_ctrl

Overview:
Controller that sequences the clause latency buffer and shares its released clauses among the BCP engines.
- Runs a load phase: forwards clauses into the buffer and counts them.
- Starts the buffer, then assigns each released clause to an idle engine in round-robin order.
- Returns the accepted count to the buffer and tracks engine occupancy.
- Signals completion when the buffer is empty and all engines are idle, or aborts on an engine conflict.

Parameters:
- NUM_ENGINE, 4, number of engines / max clauses released per cycle
- VAR_W, 11, literal width (clog2(LIT_IDX_MAX)+1)
- CLA_LENGTH, 3, literals per clause
- LOAD_MAX, 1024, max clauses per load phase

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  asynchronous, active-high reset
- load_valid_in  in  1  host presents a clause
- load_clause_in  in  VAR_W*CLA_LENGTH  host clause
- load_last_in  in  1  marks last clause of load phase
- uc_in  in  VAR_W  chosen unit clause
- uc_valid_in  in  1  chosen unit clause valid
- buf_load_sig_out  out  1  to buffer load_sig_in
- buf_clause_out  out  VAR_W*CLA_LENGTH  to buffer clause_in
- buf_start_out  out  1  to buffer start_in
- buf_uc_out  out  VAR_W  to buffer chosen_uc_in
- buf_uc_valid_out  out  1  to buffer chosen_uc_valid_in
- buf_released_in  in  clog2(NUM_ENGINE)+1  buffer clause_released_out
- buf_clause_in  in  NUM_ENGINE x VAR_W*CLA_LENGTH  buffer clause_out
- buf_empty_in  in  1  buffer empty_out
- buf_received_out  out  clog2(NUM_ENGINE)+1  to buffer clause_received_in, combinational
- eng_clause_out  out  NUM_ENGINE x VAR_W*CLA_LENGTH  clause per engine, registered
- eng_valid_out  out  NUM_ENGINE  one-cycle dispatch strobe per engine
- eng_done_in  in  NUM_ENGINE  engine finished its clause (pulse)
- eng_conflict_in  in  NUM_ENGINE  engine found a conflict (pulse)
- load_count_out  out  clog2(LOAD_MAX)+1  clauses loaded
- busy_out  out  1  state is not IDLE
- done_out  out  1  one-cycle completion pulse
- conflict_out  out  1  sticky conflict flag, cleared on next load start

Behaviour:
- Reset: every output is 0, state=IDLE, rr_ptr=0, eng_busy=0, load_count=0.
- FSM states: IDLE, LOAD, START, RUN, DRAIN, DONE.
- IDLE -> LOAD: on load_valid_in. On entry, load_count and conflict_out are cleared.
- LOAD:
  - Each load_valid_in cycle, register the clause onto buf_load_sig_out / buf_clause_out. Latency is 1 cycle, so the buffer sees it 2 cycles after input.
  - load_count increments and saturates at LOAD_MAX; load_valid_in beyond LOAD_MAX is dropped.
  - load_last_in with load_valid_in -> START.
- START:
  - Wait 2 cycles so the last clause lands in the buffer.
  - Drive buf_uc_out=uc_in and buf_uc_valid_out=uc_valid_in (pass-through, registered).
  - Then go to RUN.
- RUN:
  - buf_start_out=1 held high while in RUN and DRAIN. The buffer delays start by 1 cycle, so the first dispatch occurs 2 cycles after RUN entry.
  - Dispatch, combinational within one cycle: walk engines from rr_ptr, wrapping modulo NUM_ENGINE. Assign buf_clause_in[0..buf_released_in-1] in order to idle engines (eng_busy=0).
  - N = min(buf_released_in, idle count). buf_received_out=N. Clauses are never skipped: index k is granted only if every index below k is granted.
  - Next cycle: eng_clause_out and eng_valid_out are registered for the granted engines; eng_busy is set for them; rr_ptr moves to one past the last granted engine (unchanged if N=0).
  - eng_done_in clears eng_busy. A done arriving in the same cycle as a dispatch to the same engine is not possible, because a busy engine is never granted.
  - buf_empty_in=1 and N=0 -> DRAIN.
- DRAIN: eng_busy==0 -> DONE.
- DONE: done_out=1 for one cycle -> IDLE. buf_start_out drops.
- Conflict: any eng_conflict_in in RUN or DRAIN sets conflict_out, forces buf_received_out=0 that cycle, and goes to DONE. eng_busy is cleared.
- buf_received_out is 0 outside RUN.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- With the macro defined, two extra outputs:
  - stat_dispatched_out (32 bits): total clauses granted, wrapping.
  - stat_stall_out (32 bits): RUN cycles where buf_released_in>0 and N<buf_released_in.
  - Both are cleared on entry to LOAD.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Load 6 clauses then load_last; all engines idle and complete 1 cycle after dispatch -> load_count_out=6; first cycle dispatches 4 to engines 0-3 with buf_received_out=4; next dispatch sends 2; done_out pulses after the buffer empties and all engines are idle.
- Engines 1 and 2 busy, buf_released_in=3 -> buf_received_out=2; clauses 0 and 1 go to engines 3 and 0 (rr_ptr=3); rr_ptr becomes 1.
- All engines busy, buf_released_in=4 -> buf_received_out=0, no eng_valid_out, state remains RUN.
- eng_conflict_in[2] asserted mid-RUN -> conflict_out=1, done_out pulse next cycle, return to IDLE; conflict_out clears on the next load.
- load_last on the first clause with empty initial engines -> single dispatch to engine 0, DRAIN, done_out pulse.
- Reset asserted during RUN with engines busy -> all outputs 0 immediately; eng_busy=0; the next load starts cleanly.

Source files
------------

// File: rtl/clause_dispatch_ctrl.sv
// clause_dispatch_ctrl
//   Sequences the clause latency buffer (load, start, run) and shares the clauses it releases
//   among NUM_ENGINE BCP engines in round-robin order.
//
// Ports
//   clock, reset          : system clock (posedge), asynchronous active-high reset
//   load_*_in             : host clause stream for the load phase (load_last_in ends it)
//   uc_in, uc_valid_in    : chosen unit clause, forwarded to the buffer during START
//   buf_*_out / buf_*_in  : buffer interface; buf_received_out is combinational
//   eng_clause_out        : registered clause per engine (engine k at [k*CW +: CW])
//   eng_valid_out         : one-cycle dispatch strobe per engine
//   eng_done_in           : per-engine completion pulse
//   eng_conflict_in       : per-engine conflict pulse (aborts the run)
//   load_count_out        : clauses accepted in the current load phase (saturating)
//   busy_out, done_out    : controller active / one-cycle completion pulse
//   conflict_out          : sticky conflict flag, cleared when the next load starts
//
// Optional feature (macro DISPATCH_STATS_EN)
//   stat_dispatched_out   : total clauses granted (wrapping)
//   stat_stall_out        : RUN cycles where fewer clauses were accepted than released
module clause_dispatch_ctrl #(
    parameter int unsigned NUM_ENGINE = 4,
    parameter int unsigned VAR_W      = 11,
    parameter int unsigned CLA_LENGTH = 3,
    parameter int unsigned LOAD_MAX   = 1024
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     load_valid_in,
    input  logic [VAR_W*CLA_LENGTH-1:0]              load_clause_in,
    input  logic                                     load_last_in,
    input  logic [VAR_W-1:0]                         uc_in,
    input  logic                                     uc_valid_in,
    output logic                                     buf_load_sig_out,
    output logic [VAR_W*CLA_LENGTH-1:0]              buf_clause_out,
    output logic                                     buf_start_out,
    output logic [VAR_W-1:0]                         buf_uc_out,
    output logic                                     buf_uc_valid_out,
    input  logic [$clog2(NUM_ENGINE):0]              buf_released_in,
    input  logic [NUM_ENGINE*VAR_W*CLA_LENGTH-1:0]   buf_clause_in,
    input  logic                                     buf_empty_in,
    output logic [$clog2(NUM_ENGINE):0]              buf_received_out,
    output logic [NUM_ENGINE*VAR_W*CLA_LENGTH-1:0]   eng_clause_out,
    output logic [NUM_ENGINE-1:0]                    eng_valid_out,
    input  logic [NUM_ENGINE-1:0]                    eng_done_in,
    input  logic [NUM_ENGINE-1:0]                    eng_conflict_in,
    output logic [$clog2(LOAD_MAX):0]                load_count_out,
    output logic                                     busy_out,
    output logic                                     done_out,
`ifdef DISPATCH_STATS_EN
    output logic                                     conflict_out,
    output logic [31:0]                              stat_dispatched_out,
    output logic [31:0]                              stat_stall_out
`else
    output logic                                     conflict_out
`endif
);

    localparam int unsigned CW = VAR_W * CLA_LENGTH;
    localparam int unsigned RW = $clog2(NUM_ENGINE) + 1;
    localparam int unsigned LW = $clog2(LOAD_MAX) + 1;
    localparam int unsigned PW = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StRun, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   start_cnt_q, start_cnt_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_ENGINE-1:0]  eng_busy_q, eng_busy_d;
    logic [LW-1:0]          load_count_q, load_count_d;
    logic                   buf_load_sig_q, buf_load_sig_d;
    logic [CW-1:0]          buf_clause_q, buf_clause_d;
    logic                   buf_start_q, buf_start_d;
    logic [VAR_W-1:0]       buf_uc_q, buf_uc_d;
    logic                   buf_uc_valid_q, buf_uc_valid_d;
    logic [NUM_ENGINE*CW-1:0] eng_clause_q, eng_clause_d;
    logic [NUM_ENGINE-1:0]  eng_valid_q, eng_valid_d;
    logic                   done_q, done_d;
    logic                   conflict_q, conflict_d;
`ifdef DISPATCH_STATS_EN
    logic [31:0]            stat_disp_q, stat_disp_d;
    logic [31:0]            stat_stall_q, stat_stall_d;
`endif

    logic                   conflict_hit;
    logic [NUM_ENGINE-1:0]  grant;
    logic [RW-1:0]          n_grant;
    logic [PW-1:0]          last_eng;
    logic [NUM_ENGINE*CW-1:0] eng_clause_new;

    assign conflict_hit = (|eng_conflict_in) && (state_q == StRun || state_q == StDrain);

    // Walk engines from rr_ptr; released clauses go in order to idle engines, so a clause is
    // only granted once every lower-indexed clause has been.
    always_comb begin
        int e;
        e              = 0;
        grant          = '0;
        n_grant        = '0;
        last_eng       = rr_ptr_q;
        eng_clause_new = eng_clause_q;
        if (state_q == StRun && !conflict_hit) begin
            for (int j = 0; j < int'(NUM_ENGINE); j++) begin
                e = (int'(rr_ptr_q) + j) % int'(NUM_ENGINE);
                if (!eng_busy_q[e] && (n_grant < buf_released_in)) begin
                    grant[e]                     = 1'b1;
                    eng_clause_new[e*CW +: CW]   = buf_clause_in[int'(n_grant)*CW +: CW];
                    last_eng                     = PW'(e);
                    n_grant                      = n_grant + RW'(1);
                end
            end
        end
    end

    assign buf_received_out = n_grant;

    always_comb begin
        state_d        = state_q;
        start_cnt_d    = 1'b0;
        rr_ptr_d       = rr_ptr_q;
        eng_busy_d     = eng_busy_q & ~eng_done_in;
        load_count_d   = load_count_q;
        buf_load_sig_d = 1'b0;
        buf_clause_d   = buf_clause_q;
        buf_uc_d       = buf_uc_q;
        buf_uc_valid_d = buf_uc_valid_q;
        eng_clause_d   = eng_clause_q;
        eng_valid_d    = '0;
        conflict_d     = conflict_q;
`ifdef DISPATCH_STATS_EN
        stat_disp_d    = stat_disp_q;
        stat_stall_d   = stat_stall_q;
`endif
        unique case (state_q)
            StIdle: begin
                // The clause that opens the load phase is itself loaded.
                if (load_valid_in) begin
                    load_count_d   = LW'(1);
                    buf_load_sig_d = 1'b1;
                    buf_clause_d   = load_clause_in;
                    conflict_d     = 1'b0;
                    buf_uc_valid_d = 1'b0;
`ifdef DISPATCH_STATS_EN
                    stat_disp_d    = '0;
                    stat_stall_d   = '0;
`endif
                    state_d        = load_last_in ? StStart : StLoad;
                end
            end
            StLoad: begin
                if (load_valid_in) begin
                    if (load_count_q < LW'(LOAD_MAX)) begin
                        load_count_d   = load_count_q + LW'(1);
                        buf_load_sig_d = 1'b1;
                        buf_clause_d   = load_clause_in;
                    end
                    if (load_last_in) state_d = StStart;
                end
            end
            StStart: begin
                // Two cycles so the final registered clause reaches the buffer.
                buf_uc_d       = uc_in;
                buf_uc_valid_d = uc_valid_in;
                start_cnt_d    = 1'b1;
                if (start_cnt_q) state_d = StRun;
            end
            StRun: begin
                if (conflict_hit) begin
                    conflict_d = 1'b1;
                    eng_busy_d = '0;
                    state_d    = StDone;
                end else begin
                    eng_busy_d   = eng_busy_d | grant;
                    eng_valid_d  = grant;
                    eng_clause_d = eng_clause_new;
                    if (n_grant != '0) begin
                        rr_ptr_d = (last_eng == PW'(NUM_ENGINE - 1)) ? '0 : last_eng + PW'(1);
                    end
`ifdef DISPATCH_STATS_EN
                    stat_disp_d = stat_disp_q + 32'(n_grant);
                    if (buf_released_in != '0 && n_grant < buf_released_in) begin
                        stat_stall_d = stat_stall_q + 32'd1;
                    end
`endif
                    if (buf_empty_in && n_grant == '0) state_d = StDrain;
                end
            end
            StDrain: begin
                if (conflict_hit) begin
                    conflict_d = 1'b1;
                    eng_busy_d = '0;
                    state_d    = StDone;
                end else if (eng_busy_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        buf_start_d = (state_d == StRun) || (state_d == StDrain);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            start_cnt_q    <= 1'b0;
            rr_ptr_q       <= '0;
            eng_busy_q     <= '0;
            load_count_q   <= '0;
            buf_load_sig_q <= 1'b0;
            buf_clause_q   <= '0;
            buf_start_q    <= 1'b0;
            buf_uc_q       <= '0;
            buf_uc_valid_q <= 1'b0;
            eng_clause_q   <= '0;
            eng_valid_q    <= '0;
            done_q         <= 1'b0;
            conflict_q     <= 1'b0;
`ifdef DISPATCH_STATS_EN
            stat_disp_q    <= '0;
            stat_stall_q   <= '0;
`endif
        end else begin
            state_q        <= state_d;
            start_cnt_q    <= start_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            eng_busy_q     <= eng_busy_d;
            load_count_q   <= load_count_d;
            buf_load_sig_q <= buf_load_sig_d;
            buf_clause_q   <= buf_clause_d;
            buf_start_q    <= buf_start_d;
            buf_uc_q       <= buf_uc_d;
            buf_uc_valid_q <= buf_uc_valid_d;
            eng_clause_q   <= eng_clause_d;
            eng_valid_q    <= eng_valid_d;
            done_q         <= done_d;
            conflict_q     <= conflict_d;
`ifdef DISPATCH_STATS_EN
            stat_disp_q    <= stat_disp_d;
            stat_stall_q   <= stat_stall_d;
`endif
        end
    end

    assign buf_load_sig_out = buf_load_sig_q;
    assign buf_clause_out   = buf_clause_q;
    assign buf_start_out    = buf_start_q;
    assign buf_uc_out       = buf_uc_q;
    assign buf_uc_valid_out = buf_uc_valid_q;
    assign eng_clause_out   = eng_clause_q;
    assign eng_valid_out    = eng_valid_q;
    assign load_count_out   = load_count_q;
    assign busy_out         = (state_q != StIdle);
    assign done_out         = done_q;
    assign conflict_out     = conflict_q;
`ifdef DISPATCH_STATS_EN
    assign stat_dispatched_out = stat_disp_q;
    assign stat_stall_out      = stat_stall_q;
`endif

endmodule

// File: tb/tb_clause_dispatch_ctrl.sv
// Directed bench for clause_dispatch_ctrl; the bench plays the buffer and the engines.
module tb_clause_dispatch_ctrl;

    localparam int NE = 4;
    localparam int VW = 11;
    localparam int CL = 3;
    localparam int CW = VW * CL;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              load_valid_in = 1'b0;
    logic [CW-1:0]     load_clause_in = '0;
    logic              load_last_in = 1'b0;
    logic [VW-1:0]     uc_in = '0;
    logic              uc_valid_in = 1'b0;
    logic              buf_load_sig_out;
    logic [CW-1:0]     buf_clause_out;
    logic              buf_start_out;
    logic [VW-1:0]     buf_uc_out;
    logic              buf_uc_valid_out;
    logic [2:0]        buf_released_in = '0;
    logic [NE*CW-1:0]  buf_clause_in = '0;
    logic              buf_empty_in = 1'b0;
    logic [2:0]        buf_received_out;
    logic [NE*CW-1:0]  eng_clause_out;
    logic [NE-1:0]     eng_valid_out;
    logic [NE-1:0]     eng_done_in = '0;
    logic [NE-1:0]     eng_conflict_in = '0;
    logic [10:0]       load_count_out;
    logic              busy_out;
    logic              done_out;
    logic              conflict_out;

    int total = 0;
    int bad   = 0;

    clause_dispatch_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .load_valid_in    (load_valid_in),
        .load_clause_in   (load_clause_in),
        .load_last_in     (load_last_in),
        .uc_in            (uc_in),
        .uc_valid_in      (uc_valid_in),
        .buf_load_sig_out (buf_load_sig_out),
        .buf_clause_out   (buf_clause_out),
        .buf_start_out    (buf_start_out),
        .buf_uc_out       (buf_uc_out),
        .buf_uc_valid_out (buf_uc_valid_out),
        .buf_released_in  (buf_released_in),
        .buf_clause_in    (buf_clause_in),
        .buf_empty_in     (buf_empty_in),
        .buf_received_out (buf_received_out),
        .eng_clause_out   (eng_clause_out),
        .eng_valid_out    (eng_valid_out),
        .eng_done_in      (eng_done_in),
        .eng_conflict_in  (eng_conflict_in),
        .load_count_out   (load_count_out),
        .busy_out         (busy_out),
        .done_out         (done_out),
        .conflict_out     (conflict_out)
    );

    always #5 clock = ~clock;

    function automatic logic [CW-1:0] mk(input int k);
        logic [VW-1:0] a, b, c;
        a = VW'(k);
        b = VW'(k + 7);
        c = VW'(k * 3);
        return {a, b, c};
    endfunction

    // Engine 0 / clause index 0 is the least-significant slot.
    function automatic logic [NE*CW-1:0] pk(input logic [CW-1:0] s3, input logic [CW-1:0] s2,
                                            input logic [CW-1:0] s1, input logic [CW-1:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_count", load_count_out, 0);
        chk("rst_start", buf_start_out, 0);
        chk("rst_eng_valid", eng_valid_out, 0);
        chk("rst_conflict", conflict_out, 0);
        chk("rst_received", buf_received_out, 0);
        chk("rst_load_sig", buf_load_sig_out, 0);
        reset = 1'b0;

        // Six clauses, all engines idle
        for (int i = 0; i < 6; i++) begin
            load_valid_in  = 1'b1;
            load_clause_in = mk(i);
            load_last_in   = (i == 5);
            tick();
            chk("t1_load_sig", buf_load_sig_out, 1);
            chk("t1_load_clause", buf_clause_out, mk(i));
        end
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        uc_in         = 11'h05;
        uc_valid_in   = 1'b1;
        chk("t1_count", load_count_out, 6);
        chk("t1_busy", busy_out, 1);
        tick();
        chk("t1_uc", buf_uc_out, 11'h05);
        chk("t1_uc_valid", buf_uc_valid_out, 1);
        chk("t1_start_early", buf_start_out, 0);
        tick();
        chk("t1_start", buf_start_out, 1);
        #1;
        chk("t1_recv_idle", buf_received_out, 0);
        tick();
        buf_released_in = 3'd4;
        buf_clause_in   = pk(mk(13), mk(12), mk(11), mk(10));
        #1;
        chk("t1_recv4", buf_received_out, 4);
        tick();
        chk("t1_valid4", eng_valid_out, 4'b1111);
        chk("t1_clause4", eng_clause_out, pk(mk(13), mk(12), mk(11), mk(10)));
        eng_done_in     = 4'b1111;
        buf_released_in = 3'd2;
        buf_clause_in   = pk('0, '0, mk(15), mk(14));
        #1;
        chk("t1_recv_allbusy", buf_received_out, 0);
        tick();
        chk("t1_valid_none", eng_valid_out, 0);
        eng_done_in = '0;
        #1;
        chk("t1_recv2", buf_received_out, 2);
        tick();
        chk("t1_valid2", eng_valid_out, 4'b0011);
        chk("t1_clause2", eng_clause_out, pk(mk(13), mk(12), mk(15), mk(14)));
        buf_released_in = '0;
        buf_empty_in    = 1'b1;
        eng_done_in     = 4'b0011;
        tick();
        eng_done_in = '0;
        chk("t1_drain_busy", busy_out, 1);
        chk("t1_drain_done", done_out, 0);
        tick();
        chk("t1_done", done_out, 1);
        chk("t1_done_start", buf_start_out, 0);
        tick();
        chk("t1_done_off", done_out, 0);
        chk("t1_idle", busy_out, 0);
        buf_empty_in = 1'b0;

        // Reset in RUN with engines 2,3 busy (rr_ptr is 2)
        load_valid_in  = 1'b1;
        load_last_in   = 1'b1;
        load_clause_in = mk(20);
        tick();
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        chk("t6_count", load_count_out, 1);
        tick();
        tick();
        tick();
        buf_released_in = 3'd2;
        buf_clause_in   = pk('0, '0, mk(22), mk(21));
        tick();
        chk("t6_valid", eng_valid_out, 4'b1100);
        buf_released_in = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", eng_valid_out, 0);
        chk("t6_rst_clause", eng_clause_out, 0);
        chk("t6_rst_busy", busy_out, 0);
        chk("t6_rst_start", buf_start_out, 0);
        chk("t6_rst_count", load_count_out, 0);
        chk("t6_rst_uc_valid", buf_uc_valid_out, 0);
        tick();
        reset       = 1'b0;
        uc_valid_in = 1'b0;

        // Single clause load; dispatch to engine 0, drain, done
        load_valid_in  = 1'b1;
        load_last_in   = 1'b1;
        load_clause_in = mk(30);
        tick();
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        chk("t5_count", load_count_out, 1);
        chk("t5_load_sig", buf_load_sig_out, 1);
        tick();
        tick();
        tick();
        buf_released_in = 3'd1;
        buf_clause_in   = pk('0, '0, '0, mk(31));
        #1;
        chk("t5_recv1", buf_received_out, 1);
        tick();
        chk("t5_valid", eng_valid_out, 4'b0001);
        chk("t5_clause", eng_clause_out[CW-1:0], mk(31));
        buf_released_in = '0;
        buf_empty_in    = 1'b1;
        eng_done_in     = 4'b0001;
        tick();
        eng_done_in = '0;
        chk("t5_drain_done", done_out, 0);
        tick();
        chk("t5_done", done_out, 1);
        tick();
        chk("t5_idle", busy_out, 0);
        buf_empty_in = 1'b0;

        // rr_ptr is 1: make engines 1,2 busy, leaving rr_ptr at 3
        load_valid_in  = 1'b1;
        load_last_in   = 1'b1;
        load_clause_in = mk(40);
        tick();
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        tick();
        tick();
        tick();
        buf_released_in = 3'd2;
        buf_clause_in   = pk('0, '0, mk(42), mk(41));
        tick();
        chk("t2_pre_valid", eng_valid_out, 4'b0110);
        buf_released_in = 3'd3;
        buf_clause_in   = pk('0, mk(45), mk(44), mk(43));
        #1;
        chk("t2_recv2", buf_received_out, 2);
        tick();
        chk("t2_valid", eng_valid_out, 4'b1001);
        chk("t2_clause", eng_clause_out, pk(mk(43), mk(42), mk(41), mk(44)));

        // All engines busy
        buf_released_in = 3'd4;
        buf_clause_in   = pk(mk(49), mk(48), mk(47), mk(46));
        #1;
        chk("t3_recv0", buf_received_out, 0);
        tick();
        chk("t3_valid", eng_valid_out, 0);
        chk("t3_busy", busy_out, 1);
        chk("t3_start", buf_start_out, 1);

        // rr_ptr should now be 1: free engines 0 and 3, one clause must land on engine 3
        buf_released_in = '0;
        eng_done_in     = 4'b1001;
        tick();
        eng_done_in     = '0;
        buf_released_in = 3'd1;
        buf_clause_in   = pk('0, '0, '0, mk(46));
        #1;
        chk("t3_rr_recv", buf_received_out, 1);
        tick();
        chk("t3_rr_valid", eng_valid_out, 4'b1000);
        chk("t3_rr_clause", eng_clause_out[3*CW +: CW], mk(46));

        // Conflict on engine 2 while engine 0 is idle and a clause is offered
        buf_released_in = 3'd1;
        eng_conflict_in = 4'b0100;
        #1;
        chk("t4_recv_conflict", buf_received_out, 0);
        tick();
        eng_conflict_in = '0;
        buf_released_in = '0;
        chk("t4_conflict", conflict_out, 1);
        chk("t4_done", done_out, 1);
        chk("t4_valid", eng_valid_out, 0);
        tick();
        chk("t4_done_off", done_out, 0);
        chk("t4_idle", busy_out, 0);
        chk("t4_sticky", conflict_out, 1);

        // Next load clears conflict; then saturate the load counter
        load_valid_in  = 1'b1;
        load_last_in   = 1'b0;
        load_clause_in = mk(50);
        tick();
        chk("t4_conflict_clr", conflict_out, 0);
        chk("sat_count1", load_count_out, 1);
        for (int i = 1; i <= 1025; i++) begin
            load_clause_in = mk(i);
            load_last_in   = (i == 1025);
            tick();
        end
        load_valid_in = 1'b0;
        load_last_in  = 1'b0;
        chk("sat_count", load_count_out, 1024);
        chk("sat_dropped", buf_load_sig_out, 0);
        chk("sat_busy", busy_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
